// File: rtl/settings_bus_initiator.sv
// Settings-bus initiator: turns 64-bit command beats into settings-bus writes and
// readback-select/sample sequences, returning one 64-bit response per command.
module settings_bus_initiator #(
    parameter int unsigned AWIDTH      = 8,
    parameter int unsigned RB_SEL_ADDR = 0,
    parameter int unsigned RB_DELAY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       cmd_tdata,
    input  logic              cmd_tlast,
    input  logic              cmd_tvalid,
    output logic              cmd_tready,
    output logic [63:0]       resp_tdata,
    output logic              resp_tlast,
    output logic              resp_tvalid,
    input  logic              resp_tready,
    output logic              set_stb,
    output logic [AWIDTH-1:0] set_addr,
    output logic [31:0]       set_data,
    input  logic [31:0]       rb_data,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, WR, RBSEL, RBWAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_WRITE_READ, OP_ILLEGAL} op_t;

    localparam logic [AWIDTH-1:0] RB_SEL = AWIDTH'(RB_SEL_ADDR);
    localparam logic [3:0]        RB_CNT = 4'(RB_DELAY);

    state_t            state;
    op_t               op_q;
    logic [7:0]        seq_q;
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        wait_cnt;

    op_t               cmd_op;
    logic [7:0]        cmd_seq;
    logic [AWIDTH-1:0] cmd_addr;
    logic [31:0]       cmd_data;
    logic              unused_cmd;

    assign cmd_op   = op_t'(cmd_tdata[63:62]);
    assign cmd_seq  = cmd_tdata[47:40];
    assign cmd_addr = cmd_tdata[AWIDTH+31:32];
    assign cmd_data = cmd_tdata[31:0];
    // Bits outside the op/seq/addr/data fields carry no meaning.
    assign unused_cmd = ^cmd_tdata;

    function automatic logic [31:0] resp_hdr(input op_t op, input logic [7:0] seq,
                                             input logic [AWIDTH-1:0] addr);
        return {op, op == OP_ILLEGAL, 13'd0, seq, 8'(addr)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_tready  <= 1'b0;
            resp_tvalid <= 1'b0;
            resp_tdata  <= '0;
            resp_tlast  <= 1'b0;
            set_stb     <= 1'b0;
            set_addr    <= '0;
            set_data    <= '0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            op_q        <= OP_WRITE;
            seq_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            set_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_tvalid && cmd_tready) begin
                        op_q       <= cmd_op;
                        seq_q      <= cmd_seq;
                        addr_q     <= cmd_addr;
                        data_q     <= cmd_data;
                        resp_tlast <= cmd_tlast;
                        cmd_tready <= 1'b0;
                        busy       <= 1'b1;
                        case (cmd_op)
                            OP_WRITE, OP_WRITE_READ: begin
                                state    <= WR;
                                set_stb  <= 1'b1;
                                set_addr <= cmd_addr;
                                set_data <= cmd_data;
                            end
                            OP_READ: begin
                                state    <= RBSEL;
                                set_stb  <= 1'b1;
                                set_addr <= RB_SEL;
                                set_data <= 32'(cmd_addr);
                            end
                            default: begin
                                state       <= RESP;
                                resp_tvalid <= 1'b1;
                                resp_tdata  <= {resp_hdr(cmd_op, cmd_seq, cmd_addr), 32'hDEADBEEF};
                            end
                        endcase
                    end else begin
                        cmd_tready <= 1'b1;
                    end
                end
                WR: begin
                    if (op_q == OP_WRITE_READ) begin
                        state    <= RBSEL;
                        set_stb  <= 1'b1;
                        set_addr <= RB_SEL;
                        set_data <= 32'(addr_q);
                    end else begin
                        state       <= RESP;
                        resp_tvalid <= 1'b1;
                        resp_tdata  <= {resp_hdr(op_q, seq_q, addr_q), data_q};
                    end
                end
                RBSEL: begin
                    state    <= RBWAIT;
                    wait_cnt <= RB_CNT;
                end
                RBWAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt    <= '0;
                        state       <= RESP;
                        resp_tvalid <= 1'b1;
                        resp_tdata  <= {resp_hdr(op_q, seq_q, addr_q), rb_data};
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Ready rises the cycle after the handshake, never during it.
                    if (resp_tready) begin
                        resp_tvalid <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        cmd_tready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
